phy_tx_multilane: RTL and testbench

- Parametrised successor to the two-lane transmit PHY.
- Stripes a stream of WIDTH-bit words round-robin across LANES serial lanes.
- Each lane has one holding buffer and one shift register. Lanes emit the IDLE_CHAR symbol when no data is pending.
- All logic runs on one bit-rate clock. There is no multi-clock 32→8 conversion chain; the block sits between the upstream word source and the lane drivers.

---
 rtl/phy_tx_multilane_if.sv | 29 ++
 rtl/phy_tx_multilane.sv | 150 +++++++++++++++
 tb/tb_phy_tx_multilane.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_multilane_if.sv
// phy_tx_multilane_if: word-source handshake plus the per-lane serial outputs
// of the multilane transmit PHY. The source side uses the master modport; the
// PHY uses the slave modport.
interface phy_tx_multilane_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] out_serial;
  logic [LANES-1:0] out_active;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_serial,
    input  out_active
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_serial,
    output out_active
  );
endinterface

// File: rtl/phy_tx_multilane.sv
// phy_tx_multilane: stripes WIDTH-bit words round-robin over LANES serial
// lanes, MSB first. Each lane owns one holding buffer and one shift register;
// all lanes reload together when the shared bit counter wraps, sending
// IDLE_CHAR on any lane that has nothing pending.
// Optional feature: define PHY_TX_ACTIVE_LANES_EN to add the active_lanes
// input, which limits round-robin striping to the lowest N lanes.
module phy_tx_multilane #(
  parameter int               LANES     = 2,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_CHAR = 8'hBC
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef PHY_TX_ACTIVE_LANES_EN
  input  logic [$clog2(LANES+1)-1:0] active_lanes,
`endif
  phy_tx_multilane_if.slave          bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NW = LW + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [LW-1:0]                 lane_sel_q, lane_sel_d;
  logic [LANES-1:0][WIDTH-1:0]   hold_q, hold_d;
  logic [LANES-1:0]              hold_valid_q, hold_valid_d;
  logic [LANES-1:0][WIDTH-1:0]   shreg_q, shreg_d;
  logic [LANES-1:0]              act_q, act_d;

  logic                          load_s;
  logic                          in_ready_s;
  logic                          xfer_s;
  logic [LW-1:0]                 tgt_s;
  logic [LW-1:0]                 next_s;
  logic [LANES-1:0]              serial_s;
`ifdef PHY_TX_ACTIVE_LANES_EN
  logic [NW-1:0]                 n_s;
`endif

  assign load_s     = (cnt_q == CNT_MAX);
  // A full target lane still accepts on the load edge: its old word moves to
  // the shift register on that same edge.
  assign in_ready_s = !hold_valid_q[tgt_s] || load_s;
  assign xfer_s     = bus.in_valid && in_ready_s;

`ifdef PHY_TX_ACTIVE_LANES_EN
  // Clamp the requested lane count to 1..LANES, pick the write target and its successor
  always_comb begin
    if (active_lanes == '0) begin
      n_s = NW'(1);
    end else if (int'(active_lanes) > LANES) begin
      n_s = NW'(LANES);
    end else begin
      n_s = NW'(active_lanes);
    end
    // A lane_sel left beyond a reduced lane count restarts at lane 0.
    if ({1'b0, lane_sel_q} >= n_s) begin
      tgt_s = '0;
    end else begin
      tgt_s = lane_sel_q;
    end
    if ({1'b0, tgt_s} == (n_s - NW'(1))) begin
      next_s = '0;
    end else begin
      next_s = tgt_s + LW'(1);
    end
  end
`else
  // Write target is lane_sel itself; its successor wraps after the last lane
  always_comb begin
    tgt_s = lane_sel_q;
    if (tgt_s == LANE_LAST) begin
      next_s = '0;
    end else begin
      next_s = tgt_s + LW'(1);
    end
  end
`endif

  // Next-state: bit counter, per-lane load/shift, and the holding-buffer write
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    act_d        = act_q;
    lane_sel_d   = lane_sel_q;
    if (load_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    for (int i = 0; i < LANES; i++) begin
      if (load_s) begin
        if (hold_valid_q[i]) begin
          shreg_d[i] = hold_q[i];
        end else begin
          shreg_d[i] = IDLE_CHAR;
        end
        act_d[i]        = hold_valid_q[i];
        hold_valid_d[i] = 1'b0;
      end else begin
        shreg_d[i] = {shreg_q[i][WIDTH-2:0], 1'b0};
        act_d[i]   = act_q[i];
      end
    end
    // Applied after the load so a same-edge write keeps the lane marked full.
    if (xfer_s) begin
      hold_d[tgt_s]       = bus.in_data;
      hold_valid_d[tgt_s] = 1'b1;
      lane_sel_d          = next_s;
    end else begin
      lane_sel_d = lane_sel_q;
    end
  end

  // Serial bit of each lane is the MSB of its shift register
  always_comb begin
    serial_s = '0;
    for (int i = 0; i < LANES; i++) begin
      serial_s[i] = shreg_q[i][WIDTH-1];
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_serial = serial_s;
  assign bus.out_active = act_q;

  // State registers with synchronous reset that discards pending and in-flight words
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      lane_sel_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= '0;
      shreg_q      <= {LANES{IDLE_CHAR}};
      act_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      lane_sel_q   <= lane_sel_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      act_q        <= act_d;
    end
  end

endmodule

// File: tb/tb_phy_tx_multilane.sv
// tb_phy_tx_multilane: directed bench for phy_tx_multilane. A symbol-level
// model (per-lane word queues, bit position = counter phase) predicts every
// output each cycle; hand-computed literals pin the model.
module tb_phy_tx_multilane;
  localparam int LANES = 2;
  localparam int W     = 8;
  localparam logic [W-1:0] IDLE = 8'hBC;

  logic clk   = 1'b0;
  logic reset = 1'b1;
`ifdef PHY_TX_ACTIVE_LANES_EN
  logic [$clog2(LANES+1)-1:0] active_lanes = 2'd2;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  phy_tx_multilane_if #(.LANES(LANES), .WIDTH(W)) bus ();

  phy_tx_multilane #(.LANES(LANES), .WIDTH(W), .IDLE_CHAR(IDLE)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef PHY_TX_ACTIVE_LANES_EN
    .active_lanes (active_lanes),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int         m_cnt  = 0;
  int         m_lsel = 0;
  bit         m_xfer = 1'b0;
  logic [W-1:0] m_cur [LANES];
  bit           m_act [LANES];
  logic [W-1:0] m_pend[LANES][$];
  logic [W-1:0] m_log [LANES][$];

  function automatic int m_lanes();
`ifdef PHY_TX_ACTIVE_LANES_EN
    if (int'(active_lanes) == 0) return 1;
    if (int'(active_lanes) > LANES) return LANES;
    return int'(active_lanes);
`else
    return LANES;
`endif
  endfunction

  function automatic int m_target();
    return (m_lsel >= m_lanes()) ? 0 : m_lsel;
  endfunction

  function automatic bit m_ready();
    return (m_pend[m_target()].size() == 0) || (m_cnt == W - 1);
  endfunction

  task automatic model_step();
    bit take;
    int t;
    int n;
    if (reset) begin
      m_cnt  = 0;
      m_lsel = 0;
      m_xfer = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        m_pend[i].delete();
        m_log[i].delete();
        m_cur[i] = IDLE;
        m_act[i] = 1'b0;
      end
    end else begin
      take = bus.in_valid && m_ready();
      t    = m_target();
      n    = m_lanes();
      if (m_cnt == W - 1) begin
        for (int i = 0; i < LANES; i++) begin
          if (m_pend[i].size() > 0) begin
            m_cur[i] = m_pend[i].pop_front();
            m_act[i] = 1'b1;
            m_log[i].push_back(m_cur[i]);
          end else begin
            m_cur[i] = IDLE;
            m_act[i] = 1'b0;
          end
        end
      end
      if (take) begin
        m_pend[t].push_back(bus.in_data);
        m_lsel = (t + 1) % n;
      end
      m_xfer = take;
      m_cnt  = (m_cnt + 1) % W;
    end
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) begin
      m_cur[i] = IDLE;
      m_act[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [LANES-1:0] es;
    logic [LANES-1:0] ea;
    logic [W-1:0]     sym;
    if (chk_en) begin
      for (int i = 0; i < LANES; i++) begin
        sym   = m_cur[i];
        es[i] = sym[W - 1 - m_cnt];
        ea[i] = m_act[i];
      end
      check("out_serial", 32'(bus.out_serial), 32'(es));
      check("out_active", 32'(bus.out_active), 32'(ea));
      check("in_ready",   32'(bus.in_ready),   32'(m_ready()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    int guard = 0;
    while (m_cnt != c && guard < 64) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 64) check("wait_cnt_timeout", 32'(m_cnt), 32'(c));
  endtask

  task automatic send_at(input int c, input logic [W-1:0] d);
    wait_cnt(c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Collect one full symbol period (starting right after a load edge) per lane
  task automatic grab(output logic [W-1:0] b0, output logic [W-1:0] b1,
                      output logic [LANES-1:0] a);
    int guard = 0;
    b0 = '0;
    b1 = '0;
    @(negedge clk);
    while (m_cnt != 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("grab_timeout", 32'(m_cnt), 32'd0);
    a = bus.out_active;
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      b0 = {b0[W-2:0], bus.out_serial[0]};
      b1 = {b1[W-2:0], bus.out_serial[1]};
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [W-1:0]     b0;
    logic [W-1:0]     b1;
    logic [LANES-1:0] a;
    int               w;
    int               guard;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // 1: reset state and idle symbols
    @(posedge clk);
    chk_en = 1'b1;
    do_reset();
    @(negedge clk);
    check("t1_ready",  32'(bus.in_ready),   32'd1);
    check("t1_active", 32'(bus.out_active), 32'd0);
    check("t1_serial", 32'(bus.out_serial), 32'h3);
    for (int r = 0; r < 3; r++) begin
      grab(b0, b1, a);
      check("t1_lane0", 32'(b0), 32'hBC);
      check("t1_lane1", 32'(b1), 32'hBC);
      check("t1_act",   32'(a),  32'd0);
    end

    // 2: two words striped across both lanes
    do_reset();
    send_at(2, 8'hA5);
    send_at(3, 8'h3C);
    grab(b0, b1, a);
    check("t2_lane0", 32'(b0), 32'hA5);
    check("t2_lane1", 32'(b1), 32'h3C);
    check("t2_act",   32'(a),  32'h3);
    grab(b0, b1, a);
    check("t2_idle0", 32'(b0), 32'hBC);
    check("t2_idle1", 32'(b1), 32'hBC);
    check("t2_idle_act", 32'(a), 32'd0);

    // 3: continuous stream 0x01..0x10
    do_reset();
    w = 1;
    guard = 0;
    while (w <= 16 && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(w);
      @(posedge clk);
      #1;
      if (m_xfer) w++;
      guard++;
    end
    bus.in_valid = 1'b0;
    check("t3_stream_edges", 32'(guard), 32'd57);
    repeat (3 * W) @(posedge clk);
    #1;
    check("t3_log0_size", 32'(m_log[0].size()), 32'd8);
    check("t3_log1_size", 32'(m_log[1].size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < m_log[0].size()) check("t3_lane0_word", 32'(m_log[0][k]), 32'(2 * k + 1));
      if (k < m_log[1].size()) check("t3_lane1_word", 32'(m_log[1][k]), 32'(2 * k + 2));
    end

    // 4: write on the load edge while both holds are full
    do_reset();
    send_at(1, 8'h10);
    send_at(2, 8'h20);
    wait_cnt(5);
    check("t4_ready_full", 32'(bus.in_ready), 32'd0);
    wait_cnt(7);
    check("t4_ready_load", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    grab(b0, b1, a);
    check("t4_lane0_old", 32'(b0), 32'h10);
    check("t4_lane1_old", 32'(b1), 32'h20);
    check("t4_act_old",   32'(a),  32'h3);
    grab(b0, b1, a);
    check("t4_lane0_new", 32'(b0), 32'h77);
    check("t4_lane1_new", 32'(b1), 32'hBC);
    check("t4_act_new",   32'(a),  32'h1);

    // 5: reset in the middle of a data symbol
    do_reset();
    send_at(2, 8'hA5);
    wait_cnt(0);
    send_at(1, 8'h66);
    wait_cnt(4);
    check("t5_busy", 32'(bus.out_active), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_serial", 32'(bus.out_serial), 32'h3);
    check("t5_active", 32'(bus.out_active), 32'd0);
    check("t5_ready",  32'(bus.in_ready),   32'd1);
    grab(b0, b1, a);
    check("t5_drop0", 32'(b0), 32'hBC);
    check("t5_drop1", 32'(b1), 32'hBC);
    check("t5_drop_act", 32'(a), 32'd0);
    send_at(2, 8'h5A);
    grab(b0, b1, a);
    check("t5_first0", 32'(b0), 32'h5A);
    check("t5_first1", 32'(b1), 32'hBC);
    check("t5_first_act", 32'(a), 32'h1);

`ifdef PHY_TX_ACTIVE_LANES_EN
    // 6: single active lane, then active_lanes=0 behaves the same
    for (int r = 0; r < 2; r++) begin
      active_lanes = (r == 0) ? 2'd1 : 2'd0;
      do_reset();
      send_at(2, 8'h11);
      send_at(7, 8'h22);
      grab(b0, b1, a);
      check("t6_lane0_a", 32'(b0), 32'h11);
      check("t6_lane1_a", 32'(b1), 32'hBC);
      check("t6_act_a",   32'(a),  32'h1);
      grab(b0, b1, a);
      check("t6_lane0_b", 32'(b0), 32'h22);
      check("t6_lane1_b", 32'(b1), 32'hBC);
      check("t6_act_b",   32'(a),  32'h1);
    end
    active_lanes = 2'd2;
`endif

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
